// File: rtl/me_pkg.sv
// Shared sizes, state encoding and pixel helpers for the 4x4 full-search motion estimator.
package me_pkg;

  localparam int unsigned Blk   = 4;
  localparam int unsigned Sr    = 2;
  localparam int unsigned Win   = Blk + 2 * Sr;
  localparam int unsigned NCand = (2 * Sr + 1) * (2 * Sr + 1);
  localparam int unsigned PixW  = 8;
  localparam int unsigned SadW  = 12;
  localparam int unsigned MvW   = 3;
  localparam int unsigned NPix  = Blk * Blk;

  typedef enum logic [2:0] {
    StIdle,
    StLoadCur,
    StLoadRef,
    StDrain,
    StSearch,
    StDone
  } me_state_e;

  // 16 pixels of one 4x4 block, index j*Blk+i
  typedef logic [NPix-1:0][PixW-1:0] blk_pix_t;

  function automatic logic [PixW:0] abs_diff(input logic [PixW-1:0] a, input logic [PixW-1:0] b);
    logic [PixW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[PixW] ? -d : d;
  endfunction

endpackage

// File: rtl/me_sad4x4.sv
// Combinational sum of absolute differences over one 4x4 candidate.
module me_sad4x4
  import me_pkg::*;
(
  input  blk_pix_t          cur_px_i,
  input  blk_pix_t          cand_px_i,
  output logic [SadW-1:0]   sad_o
);

  always_comb begin
    sad_o = '0;
    for (int k = 0; k < int'(NPix); k++) begin
      sad_o = sad_o + SadW'(abs_diff(cur_px_i[k], cand_px_i[k]));
    end
  end

endmodule

// File: rtl/motion_estimator.sv
// Full-search (+/-2) block matcher: fetches a 4x4 block and 8x8 window, reports the min-SAD vector.
module motion_estimator
  import me_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Blk*PixW-1:0]  cur_in,
  input  logic [Win*PixW-1:0]  ref_in,
  output logic                 need_cur,
  output logic                 need_ref,
  output logic                 mv_valid,
  output logic [MvW-1:0]       mv_x,
  output logic [MvW-1:0]       mv_y,
  output logic [SadW-1:0]      best_sad
);

  localparam logic [2:0] CMax   = 3'(2 * Sr);
  localparam logic [2:0] CurEnd = 3'(Blk - 1);
  localparam logic [2:0] RefEnd = 3'(Win - 1);

  me_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] cx_q, cx_d, cy_q, cy_d;

  // Word requested at edge k arrives for capture at edge k+1
  logic       cap_cur_q, cap_ref_q;
  logic [2:0] cap_row_q;

  logic [Blk*PixW-1:0] cur_q [Blk];
  logic [Win*PixW-1:0] win_q [Win];

  logic [SadW-1:0] bsad_q, bsad_d;
  logic [2:0]      bcx_q, bcx_d, bcy_q, bcy_d;
  logic [MvW-1:0]  mv_x_q, mv_y_q;
  logic [SadW-1:0] best_sad_q;

  blk_pix_t        cur_px, cand_px;
  logic [SadW-1:0] sad;
  logic            first_cand, last_cand;

  assign first_cand = (cx_q == 3'd0) && (cy_q == 3'd0);
  assign last_cand  = (cx_q == CMax) && (cy_q == CMax);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    need_cur = 1'b0;
    need_ref = 1'b0;
    mv_valid = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = StLoadCur;
        cnt_d   = 3'd0;
      end
      StLoadCur: begin
        need_cur = 1'b1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == CurEnd) begin
          state_d = StLoadRef;
          cnt_d   = 3'd0;
        end
      end
      StLoadRef: begin
        need_ref = 1'b1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == RefEnd) begin
          state_d = StDrain;
          cnt_d   = 3'd0;
        end
      end
      StDrain: begin
        state_d = StSearch;
        cx_d    = 3'd0;
        cy_d    = 3'd0;
      end
      StSearch: begin
        if (cx_q == CMax) begin
          cx_d = 3'd0;
          cy_d = cy_q + 3'd1;
        end else begin
          cx_d = cx_q + 3'd1;
        end
        if (last_cand) state_d = StDone;
      end
      StDone: begin
        mv_valid = 1'b1;
        state_d  = StLoadCur;
        cnt_d    = 3'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      cx_q      <= 3'd0;
      cy_q      <= 3'd0;
      cap_cur_q <= 1'b0;
      cap_ref_q <= 1'b0;
      cap_row_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      cap_cur_q <= need_cur;
      cap_ref_q <= need_ref;
      cap_row_q <= cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(Blk); r++) cur_q[r] <= '0;
      for (int r = 0; r < int'(Win); r++) win_q[r] <= '0;
    end else begin
      if (cap_cur_q) cur_q[cap_row_q[1:0]] <= cur_in;
      if (cap_ref_q) win_q[cap_row_q] <= ref_in;
    end
  end

  // Candidate (cx,cy) is the 4x4 window region whose top-left pixel is win[cy][cx]
  always_comb begin
    cur_px  = '0;
    cand_px = '0;
    for (int j = 0; j < int'(Blk); j++) begin
      for (int i = 0; i < int'(Blk); i++) begin
        cur_px[j*Blk+i]  = cur_q[j][i*PixW +: PixW];
        cand_px[j*Blk+i] = win_q[cy_q + 3'(j)][{cx_q + 3'(i), 3'b000} +: PixW];
      end
    end
  end

  me_sad4x4 u_sad (
    .cur_px_i  (cur_px),
    .cand_px_i (cand_px),
    .sad_o     (sad)
  );

  // Strict less-than keeps the earliest candidate in raster order on ties
  always_comb begin
    bsad_d = bsad_q;
    bcx_d  = bcx_q;
    bcy_d  = bcy_q;
    if ((state_q == StSearch) && (first_cand || (sad < bsad_q))) begin
      bsad_d = sad;
      bcx_d  = cx_q;
      bcy_d  = cy_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsad_q     <= '0;
      bcx_q      <= 3'd0;
      bcy_q      <= 3'd0;
      mv_x_q     <= '0;
      mv_y_q     <= '0;
      best_sad_q <= '0;
    end else begin
      bsad_q <= bsad_d;
      bcx_q  <= bcx_d;
      bcy_q  <= bcy_d;
      // Outputs load on the edge entering DONE, including the final candidate
      if ((state_q == StSearch) && last_cand) begin
        mv_x_q     <= MvW'(bcx_d - 3'(Sr));
        mv_y_q     <= MvW'(bcy_d - 3'(Sr));
        best_sad_q <= bsad_d;
      end
    end
  end

  assign mv_x     = mv_x_q;
  assign mv_y     = mv_y_q;
  assign best_sad = best_sad_q;

endmodule

// File: tb/tb_motion_estimator.sv
// Directed bench: fetch agent, arithmetic full-search model and per-cycle output checker.
module tb_motion_estimator;

  localparam int NB = 6;

  logic        clk;
  logic        rst;
  logic [31:0] cur_in;
  logic [63:0] ref_in;
  logic        need_cur, need_ref, mv_valid;
  logic [2:0]  mv_x, mv_y;
  logic [11:0] best_sad;

  motion_estimator dut (
    .clk      (clk),
    .rst      (rst),
    .cur_in   (cur_in),
    .ref_in   (ref_in),
    .need_cur (need_cur),
    .need_ref (need_ref),
    .mv_valid (mv_valid),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .best_sad (best_sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int s;
  } res_t;

  int   cur_mem [NB][4][4];
  int   win_mem [NB][8][8];
  res_t exp_q[$];

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int n_valid = 0;
  bit have_res = 0;
  int last_x = 0, last_y = 0, last_s = 0;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Exhaustive search over dy,dx in -2..2, first strict minimum wins
  function automatic void model(input int b, output int ex, output int ey, output int es);
    int s, d;
    es = -1;
    ex = 0;
    ey = 0;
    for (int dy = -2; dy <= 2; dy++) begin
      for (int dx = -2; dx <= 2; dx++) begin
        s = 0;
        for (int j = 0; j < 4; j++) begin
          for (int i = 0; i < 4; i++) begin
            d = cur_mem[b][j][i] - win_mem[b][2+dy+j][2+dx+i];
            s += (d < 0) ? -d : d;
          end
        end
        if (es < 0 || s < es) begin
          es = s;
          ex = dx;
          ey = dy;
        end
      end
    end
  endfunction

  // Fetch agent: a request seen in a cycle is answered right after the following edge
  initial begin : agent
    int  cur_row, ref_row, ag_blk;
    bit  req_c, req_r;
    res_t r;
    cur_row = 0;
    ref_row = 0;
    ag_blk  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_row = 0;
        ref_row = 0;
        req_c   = 0;
        req_r   = 0;
      end else begin
        req_c = need_cur;
        req_r = need_ref;
      end
      @(posedge clk);
      #1;
      if (req_c) begin
        for (int i = 0; i < 4; i++) cur_in[i*8 +: 8] = 8'(cur_mem[ag_blk][cur_row % 4][i]);
        cur_row++;
      end
      if (req_r) begin
        for (int x = 0; x < 8; x++) ref_in[x*8 +: 8] = 8'(win_mem[ag_blk][ref_row % 8][x]);
        ref_row++;
        if (ref_row == 8) begin
          model(ag_blk, r.x, r.y, r.s);
          exp_q.push_back(r);
          ag_blk  = (ag_blk + 1) % NB;
          ref_row = 0;
          cur_row = 0;
        end
      end
    end
  end

  // Per-cycle checker: request/valid timing from cycle phase, outputs against model results
  initial begin : monitor
    int   p;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc      = 0;
        have_res = 0;
        exp_q.delete();
      end else begin
        cyc++;
        p = (cyc >= 2) ? (cyc - 2) % 39 : -1;
        check("need_cur_timing", int'(need_cur), int'(p >= 0 && p < 4));
        check("need_ref_timing", int'(need_ref), int'(p >= 4 && p < 12));
        check("mv_valid_timing", int'(mv_valid), int'(p == 38));
        check("need_exclusive", int'(need_cur & need_ref), 0);
        if (mv_valid) begin
          n_valid++;
          if (exp_q.size() == 0) begin
            check("result_queued", exp_q.size(), 1);
          end else begin
            r        = exp_q.pop_front();
            last_x   = r.x;
            last_y   = r.y;
            last_s   = r.s;
            have_res = 1;
          end
        end
        check("mv_x", int'($signed(mv_x)), have_res ? last_x : 0);
        check("mv_y", int'($signed(mv_y)), have_res ? last_y : 0);
        check("best_sad", int'(best_sad), have_res ? last_s : 0);
      end
    end
  end

  task automatic wait_pulses(input int target);
    for (int k = 0; k < 400 && n_valid < target; k++) @(negedge clk);
    #1;
    check("pulse_count", n_valid, target);
  endtask

  initial begin : stim
    int ex, ey, es;
    rst    = 1'b1;
    cur_in = '0;
    ref_in = '0;

    for (int b = 0; b < NB; b++) begin
      for (int y = 0; y < 8; y++) begin
        for (int x = 0; x < 8; x++) begin
          case (b)
            0:       win_mem[b][y][x] = 200;
            1:       win_mem[b][y][x] = 0;
            2:       win_mem[b][y][x] = 0;
            3:       win_mem[b][y][x] = (x * 53 + y * 29 + 7 * x * y) % 256;
            4:       win_mem[b][y][x] = (x * x * 13 + y * 71 + 3) % 256;
            default: win_mem[b][y][x] = (x * 17 + y * y * 5 + 90) % 256;
          endcase
        end
      end
      for (int j = 0; j < 4; j++) begin
        for (int i = 0; i < 4; i++) begin
          case (b)
            0: begin
              cur_mem[b][j][i]         = j * 4 + i + 1;
              win_mem[b][2+j][2+i]     = j * 4 + i + 1;
            end
            1: begin
              cur_mem[b][j][i]         = 100;
              win_mem[b][j][3+i]       = 100;
            end
            2:       cur_mem[b][j][i] = 255;
            3:       cur_mem[b][j][i] = (i * 37 + j * 11 + 5) % 256;
            4:       cur_mem[b][j][i] = win_mem[b][3+j][1+i] ^ ((i == 0 && j == 0) ? 1 : 0);
            default: cur_mem[b][j][i] = win_mem[b][1+j][4+i];
          endcase
        end
      end
    end

    // Hand-derived results pin the model
    model(0, ex, ey, es);
    check("model_zero_x", ex, 0);
    check("model_zero_y", ey, 0);
    check("model_zero_sad", es, 0);
    model(1, ex, ey, es);
    check("model_shift_x", ex, 1);
    check("model_shift_y", ey, -2);
    check("model_shift_sad", es, 0);
    model(2, ex, ey, es);
    check("model_tie_x", ex, -2);
    check("model_tie_y", ey, -2);
    check("model_tie_sad", es, 4080);

    repeat (3) @(posedge clk);
    #1;
    check("rst_need_cur", int'(need_cur), 0);
    check("rst_need_ref", int'(need_ref), 0);
    check("rst_mv_valid", int'(mv_valid), 0);
    check("rst_mv_x", int'(mv_x), 0);
    check("rst_mv_y", int'(mv_y), 0);
    check("rst_best_sad", int'(best_sad), 0);

    @(posedge clk);
    #2 rst = 1'b0;

    // Four blocks streamed back to back
    wait_pulses(4);

    // Abort block 4 during its 5th window-row request
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (cyc >= 2 && (cyc - 2) % 39 == 8) break;
    end
    check("abort_phase", (cyc - 2) % 39, 8);
    #1 rst = 1'b1;
    #1;
    check("abort_need_ref", int'(need_ref), 0);
    check("abort_mv_valid", int'(mv_valid), 0);
    check("abort_mv_x", int'(mv_x), 0);
    check("abort_mv_y", int'(mv_y), 0);
    check("abort_best_sad", int'(best_sad), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Block 4 refetched from row 0, then block 5
    wait_pulses(6);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
